// File: rtl/spice_node_integrator.sv
// spice_node_integrator: sums branch currents on one node and integrates them into a clamped
// node voltage over a 2-stage pipeline, with logic level and settle detection.
module spice_node_integrator #(
    parameter int             W         = 16,
    parameter int             N_I       = 4,
    parameter int             CAP_SHIFT = 2,
    parameter logic [W-1:0]   V_HI      = 16'h4000,
    parameter logic [W-1:0]   V_LO      = 16'hC000,
    parameter logic [W-1:0]   V_INIT    = 16'hC000,
    parameter int             TOL       = 4,
    parameter int             SETTLE_N  = 8
) (
    input  logic             eclk,
    input  logic             ereset_n,
    input  logic             step,
    input  logic [N_I*W-1:0] i_in,
    input  logic             load,
    input  logic [W-1:0]     load_v,
    output logic [W-1:0]     v,
    output logic             level,
    output logic             settled,
    output logic             busy
);
    localparam int SW = W + $clog2(N_I);
    localparam int AW = SW + 1;
    localparam logic signed [W-1:0]  V_HI_S = V_HI;
    localparam logic signed [W-1:0]  V_LO_S = V_LO;
    localparam logic signed [SW-1:0] TOL_S  = SW'(TOL);
    localparam logic [7:0]           SN     = 8'(SETTLE_N);

    logic [W-1:0]         v_q, v_d, v_clamp, load_clamp;
    logic signed [SW-1:0] sum_q, sum_d, sum_all, delta;
    logic signed [AW-1:0] v_sum;
    logic                 busy_q, busy_d, settled_q, settled_d, quiet;
    logic [7:0]           cnt_q, cnt_d;

    always_comb begin
        sum_all = '0;
        for (int k = 0; k < N_I; k++) sum_all = sum_all + SW'($signed(i_in[k*W +: W]));
        delta      = sum_q >>> CAP_SHIFT;
        v_sum      = AW'($signed(v_q)) + AW'(delta);
        v_clamp    = v_sum > AW'(V_HI_S) ? V_HI : v_sum < AW'(V_LO_S) ? V_LO : v_sum[W-1:0];
        load_clamp = $signed(load_v) > V_HI_S ? V_HI : $signed(load_v) < V_LO_S ? V_LO : load_v;
        // pushing further into a rail leaves v unchanged, so it counts as quiet
        quiet      = (delta <= TOL_S && delta >= -TOL_S) || (v_q == V_HI && !delta[SW-1])
                     || (v_q == V_LO && delta[SW-1]);
        v_d        = v_q;
        sum_d      = sum_q;
        busy_d     = 1'b0;
        cnt_d      = cnt_q;
        settled_d  = settled_q;
        if (load) begin
            v_d       = load_clamp;
            cnt_d     = '0;
            settled_d = 1'b0;
        end else begin
            if (step) begin
                sum_d  = sum_all;
                busy_d = 1'b1;
            end
            if (busy_q) begin
                v_d       = v_clamp;
                cnt_d     = quiet ? (cnt_q == SN ? SN : cnt_q + 8'd1) : '0;
                settled_d = quiet && cnt_d == SN;
            end
        end
    end

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            v_q       <= V_INIT;
            sum_q     <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            settled_q <= 1'b0;
        end else begin
            v_q       <= v_d;
            sum_q     <= sum_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
        end
    end

    assign v       = v_q;
    assign level   = ~v_q[W-1];
    assign settled = settled_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_spice_node_integrator.sv
// tb_spice_node_integrator: directed checks of reset, charge, saturation, discharge,
// settle tracking and load priority.
module tb_spice_node_integrator;
    localparam int W = 16;
    localparam int N_I = 4;

    logic             eclk = 1'b0;
    logic             ereset_n = 1'b0;
    logic             step = 1'b0;
    logic [N_I*W-1:0] i_in = '0;
    logic             load = 1'b0;
    logic [W-1:0]     load_v = '0;
    logic [W-1:0]     v;
    logic             level, settled, busy;
    int               checks = 0;
    int               errors = 0;

    spice_node_integrator dut (
        .eclk(eclk), .ereset_n(ereset_n), .step(step), .i_in(i_in), .load(load),
        .load_v(load_v), .v(v), .level(level), .settled(settled), .busy(busy)
    );

    always #5 eclk = ~eclk;

    task automatic tick();
        @(posedge eclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [W-1:0] val);
        load = 1'b1;
        load_v = val;
        tick();
        load = 1'b0;
    endtask

    initial begin
        // reset held with step active
        step = 1'b1;
        i_in = {4{16'd100}};
        repeat (3) tick();
        chk("rst_v", v, 16'hC000);
        chk("rst_level", 16'(level), 16'd0);
        chk("rst_settled", 16'(settled), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        ereset_n = 1'b1;
        step = 1'b0;
        repeat (3) tick();
        chk("rst_release_v", v, 16'hC000);
        chk("rst_release_busy", 16'(busy), 16'd0);

        // charge
        do_load(16'h0000);
        i_in = {16'd0, 16'd0, 16'd0, 16'd64};
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("charge_busy", 16'(busy), 16'd1);
        chk("charge_v_t1", v, 16'h0000);
        tick();
        chk("charge_v", v, 16'd16);
        chk("charge_level", 16'(level), 16'd1);
        chk("charge_busy_clr", 16'(busy), 16'd0);

        // saturation at upper rail
        do_load(16'h3FF0);
        i_in = {4{16'd4000}};
        step = 1'b1;
        tick();
        tick();
        chk("sat_first", v, 16'h4000);
        tick();
        step = 1'b0;
        tick();
        chk("sat_hold", v, 16'h4000);
        tick();
        chk("sat_idle", v, 16'h4000);

        // discharge to lower rail
        do_load(16'h0000);
        i_in = {16'h0000, 16'h0000, 16'hFF9C, 16'hFF9C};
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("neg_v", v, 16'hFFCE);
        chk("neg_level", 16'(level), 16'd0);
        step = 1'b1;
        repeat (340) tick();
        step = 1'b0;
        repeat (2) tick();
        chk("neg_rail", v, 16'hC000);

        // load clamps to rail
        do_load(16'h7000);
        chk("load_clamp", v, 16'h4000);

        // settling with zero current
        do_load(16'h0000);
        i_in = '0;
        step = 1'b1;
        repeat (8) tick();
        step = 1'b0;
        chk("settle_7", 16'(settled), 16'd0);
        tick();
        chk("settle_8", 16'(settled), 16'd1);
        i_in = {16'd0, 16'd0, 16'd0, 16'd20};
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("unsettle_s1", 16'(settled), 16'd1);
        tick();
        chk("unsettle", 16'(settled), 16'd0);
        chk("unsettle_v", v, 16'd5);
        // delta exactly TOL is quiet; counter restarted from zero
        i_in = {16'd0, 16'd0, 16'd0, 16'd16};
        step = 1'b1;
        repeat (8) tick();
        step = 1'b0;
        chk("tol_7", 16'(settled), 16'd0);
        tick();
        chk("tol_8", 16'(settled), 16'd1);
        chk("tol_v", v, 16'd37);

        // load/step collision
        i_in = {16'd0, 16'd0, 16'd0, 16'd64};
        step = 1'b1;
        tick();
        load = 1'b1;
        load_v = 16'h1234;
        tick();
        load = 1'b0;
        step = 1'b0;
        chk("coll_v", v, 16'h1234);
        chk("coll_busy", 16'(busy), 16'd0);
        chk("coll_settled", 16'(settled), 16'd0);
        repeat (2) tick();
        chk("coll_hold", v, 16'h1234);

        // reset mid-step
        step = 1'b1;
        tick();
        step = 1'b0;
        ereset_n = 1'b0;
        #1;
        chk("midrst_v", v, 16'hC000);
        chk("midrst_busy", 16'(busy), 16'd0);
        ereset_n = 1'b1;
        repeat (2) tick();
        chk("midrst_hold", v, 16'hC000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
